// File: rtl/uart_pkg.sv
// uart_pkg - shared types, constants and helpers for the oversampled UART.
//
// Contents:
//   rx_state_t   receiver FSM state encoding
//   MAJ_LO/MAJ_HI/LAST_SAMPLE  sample-counter positions within one bit
//   baud_div()   oversample tick divider from clock and line rate
//   majority3()  2-of-3 vote
//   even_parity() XOR reduction of a data byte
// Optional feature macro used by the users of this package: UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Sample-counter positions: the vote uses samples 7,8,9 (bit centre) and
  // the bit ends at sample 15.
  localparam logic [3:0] MAJ_LO      = 4'd7;
  localparam logic [3:0] MAJ_HI      = 4'd9;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity bit for a byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick - free-running divider producing a 1-cycle oversample tick.
//
// Ports:
//   clk    in  1  clock, rising edge
//   rst    in  1  synchronous active-high reset
//   clear  in  1  synchronous restart of the count at 0 (suppresses tick)
//   tick   out 1  high for one cycle every DIV cycles
// Shared between the receiver and the oversampled transmitter.
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: wraps at DIV-1, restarts on clear or reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt == CNT_MAX) && !clear;

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 8N1 UART receiver, 16x oversampling, 3-sample majority vote,
// one-byte valid/ready holding register.
//
// Ports:
//   hwclk      in  1  system clock, rising edge
//   rst        in  1  synchronous active-high reset
//   rx         in  1  asynchronous UART line, idle high
//   rxbyte     out 8  received byte, stable while rx_valid=1
//   rx_valid   out 1  rxbyte holds an unconsumed byte
//   rx_ready   in  1  consumer accepts; transfer when rx_valid && rx_ready
//   frame_err  out 1  1-cycle pulse: stop bit sampled low
//   overrun    out 1  1-cycle pulse: byte completed while holding reg full
//   parity_err out 1  (UART_RX_PARITY_EN only) 1-cycle pulse on parity mismatch
//
// Configuration macro: UART_RX_PARITY_EN selects 8E1 framing (adds PARITY
// state and parity_err). Undefined: 8N1.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       overrun,
  output logic       parity_err
`else
  output logic       overrun
`endif
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);

  logic       rx_meta;
  logic       rx_s;
  rx_state_t  state;
  rx_state_t  state_next;
  logic [3:0] scnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       samp_a;
  logic       samp_b;
  logic       tick;
  logic       clear_div;
  logic       maj;
  logic       decide;
  logic       at_end;
  logic       parity_ok;
  logic       byte_done;
  logic       ferr_set;
  logic       perr_set;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (hwclk),
    .rst   (rst),
    .clear (clear_div),
    .tick  (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Vote uses the two stored samples plus the live sample at position 9.
  assign maj    = majority3(samp_a, samp_b, rx_s);
  assign decide = tick && (scnt == MAJ_HI);
  assign at_end = tick && (scnt == LAST_SAMPLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Captured parity bit, voted like a data bit.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if ((state == PARITY) && decide) begin
      par_bit <= maj;
    end else begin
      par_bit <= par_bit;
    end
  end

  assign parity_ok = (par_bit == even_parity(shreg));
`else
  assign parity_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
        else       state_next = IDLE;
      end
      START: begin
        if (decide && maj) state_next = IDLE;   // glitch shorter than half a bit
        else if (at_end)   state_next = DATA;
        else               state_next = START;
      end
      DATA: begin
        if (at_end && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (at_end) state_next = STOP;
        else        state_next = PARITY;
      end
      STOP: begin
        // Leave at the stop-bit centre so the next start edge is never missed.
        if (decide) state_next = maj ? IDLE : BREAK;
        else        state_next = STOP;
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
        else      state_next = BREAK;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: divider restart and the stop-decision event strobes.
  always_comb begin
    clear_div = 1'b0;
    byte_done = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    case (state)
      IDLE: begin
        clear_div = !rx_s;
      end
      STOP: begin
        if (decide) begin
          byte_done = maj && parity_ok;
          ferr_set  = !maj;
          perr_set  = maj && !parity_ok;
        end else begin
          byte_done = 1'b0;
        end
      end
      default: begin
        clear_div = 1'b0;
      end
    endcase
  end

  // Sample counter, vote samples, bit index and LSB-first shift register.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      scnt    <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else if (state == IDLE) begin
      scnt    <= 4'd0;
      bit_idx <= 3'd0;
    end else if (tick) begin
      scnt <= scnt + 4'd1;
      if (scnt == MAJ_LO)           samp_a <= rx_s;
      if (scnt == (MAJ_LO + 4'd1))  samp_b <= rx_s;
      if ((state == DATA) && (scnt == MAJ_HI)) shreg <= {maj, shreg[7:1]};
      if ((state == DATA) && (scnt == LAST_SAMPLE)) bit_idx <= bit_idx + 3'd1;
    end
  end

  // Holding register and registered error pulses.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      rxbyte    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= byte_done && rx_valid && !rx_ready;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rxbyte   <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity error pulse.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_set;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Testbench for uart_rx_os16. Runs with a divider of 16 (256-cycle bit) so
// the full scenario list stays short; glitch length is scaled accordingly.
module tb_uart_rx_os16;

  localparam int CLK_HZ = 2457600;
  localparam int BAUD   = 9600;
  localparam int BIT    = 256;

  logic       hwclk = 1'b0;
  logic       rst   = 1'b1;
  logic       rx    = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rxbyte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .rx        (rx),
    .rxbyte    (rxbyte),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .overrun   (overrun),
    .parity_err(parity_err)
`else
    .overrun   (overrun)
`endif
  );

  always #5 hwclk = ~hwclk;

  // Observation record: accepted bytes and event counters.
  logic [7:0] got_mem [0:255];
  int got_n = 0, valid_cyc = 0, ferr_n = 0, ovr_n = 0, perr_n = 0, both_n = 0;

  always @(negedge hwclk) begin
    if (rx_valid === 1'b1) valid_cyc++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got_mem[got_n[7:0]] = rxbyte;
      got_n++;
    end
    if (frame_err === 1'b1) ferr_n++;
    if (overrun === 1'b1) ovr_n++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_n++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_n++;
`endif
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge hwclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_en, input logic par_b);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (par_en) drive(par_b, BIT);
    drive(stop_b, BIT);
  endtask

  task automatic send_byte(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
    send_frame(d, 1'b1, 1'b1, ^d);
`else
    send_frame(d, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    repeat (5) @(negedge hwclk);
    checks++; if (rxbyte !== 8'h00) begin errors++; $display("FAIL reset_rxbyte got %h want 00", rxbyte); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst = 1'b0;
    drive(1'b1, BIT);
  endtask

  task automatic test_single;
    int n0, v0, f0, o0;
    rx_ready = 1'b1;
    n0 = got_n; v0 = valid_cyc; f0 = ferr_n; o0 = ovr_n;
    send_byte(8'hA5);
    drive(1'b1, BIT);
    checks++; if (got_n - n0 !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_n - n0); end
    checks++; if (got_mem[n0[7:0]] !== 8'hA5) begin errors++; $display("FAIL single_byte got %h want a5", got_mem[n0[7:0]]); end
    checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got %0d want 1", valid_cyc - v0); end
    checks++; if (ferr_n - f0 !== 0 || ovr_n - o0 !== 0) begin errors++; $display("FAIL single_errors got ferr %0d ovr %0d want 0 0", ferr_n - f0, ovr_n - o0); end
  endtask

  task automatic test_back_to_back;
    int n0, f0, o0;
    rx_ready = 1'b0;
    n0 = got_n; f0 = ferr_n; o0 = ovr_n;
    send_byte(8'h3C);
    send_byte(8'hC3);
    drive(1'b1, BIT);
    checks++; if (ovr_n - o0 !== 1) begin errors++; $display("FAIL b2b_overrun got %0d want 1", ovr_n - o0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held got %b want 1", rx_valid); end
    checks++; if (rxbyte !== 8'h3C) begin errors++; $display("FAIL b2b_held_byte got %h want 3c", rxbyte); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d want 0", ferr_n - f0); end
    rx_ready = 1'b1;
    repeat (4) @(negedge hwclk);
    checks++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h3C) begin errors++; $display("FAIL b2b_consume got n=%0d byte %h want n=1 byte 3c", got_n - n0, got_mem[n0[7:0]]); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_fall got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cyc; f0 = ferr_n;
    drive(1'b0, (BIT * 300) / 1248);
    drive(1'b1, 3 * BIT);
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_cyc - v0); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", ferr_n - f0); end
  endtask

  task automatic test_break;
    int n0, v0, f0;
    rx_ready = 1'b1;
    v0 = valid_cyc; f0 = ferr_n;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5 * BIT);
    drive(1'b1, 2 * BIT);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL break_frame_err got %0d want 1", ferr_n - f0); end
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL break_valid got %0d want 0", valid_cyc - v0); end
    n0 = got_n;
    send_byte(8'h12);
    drive(1'b1, BIT);
    checks++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h12) begin errors++; $display("FAIL break_recover got n=%0d byte %h want n=1 byte 12", got_n - n0, got_mem[n0[7:0]]); end
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL break_single_err got %0d want 1", ferr_n - f0); end
  endtask

  task automatic test_reset_midframe;
    int n0, v0, f0, o0;
    rx_ready = 1'b0;
    send_byte(8'h5A);
    drive(1'b1, BIT);
    checks++; if (rx_valid !== 1'b1 || rxbyte !== 8'h5A) begin errors++; $display("FAIL midrst_pre got valid %b byte %h want 1 5a", rx_valid, rxbyte); end
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT);
    drive(1'b1, BIT / 2);
    rst = 1'b1;
    @(negedge hwclk);
    checks++; if (rx_valid !== 1'b0 || rxbyte !== 8'h00) begin errors++; $display("FAIL midrst_outputs got valid %b byte %h want 0 00", rx_valid, rxbyte); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_pulses got ferr %b ovr %b want 0 0", frame_err, overrun); end
    rst = 1'b0;
    v0 = valid_cyc; f0 = ferr_n; o0 = ovr_n;
    drive(1'b1, BIT / 2 + 5 * BIT);
    checks++; if (valid_cyc - v0 !== 0 || ferr_n - f0 !== 0 || ovr_n - o0 !== 0) begin errors++; $display("FAIL midrst_quiet got valid %0d ferr %0d ovr %0d want 0 0 0", valid_cyc - v0, ferr_n - f0, ovr_n - o0); end
    rx_ready = 1'b1;
    n0 = got_n;
    send_byte(8'h81);
    drive(1'b1, BIT);
    checks++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h81) begin errors++; $display("FAIL midrst_next got n=%0d byte %h want n=1 byte 81", got_n - n0, got_mem[n0[7:0]]); end
  endtask

  task automatic test_random_stream;
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int n0;
    rx_ready = 1'b1;
    n0 = got_n;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b);
      drive(1'b1, $urandom_range(0, 2 * BIT));
    end
    drive(1'b1, BIT);
    checks++; if (got_n - n0 !== 6) begin errors++; $display("FAIL rand_count got %0d want 6", got_n - n0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_mem[8'(n0 + k)] !== exp_q[k]) begin
        errors++; $display("FAIL rand_byte%0d got %h want %h", k, got_mem[8'(n0 + k)], exp_q[k]);
      end
    end
  endtask

  task automatic test_random_overrun;
    logic [7:0] first;
    int cnt, n0, o0;
    rx_ready = 1'b0;
    cnt = $urandom_range(2, 4);
    o0 = ovr_n; n0 = got_n;
    first = 8'($urandom);
    send_byte(first);
    for (int k = 1; k < cnt; k++) begin
      drive(1'b1, $urandom_range(0, BIT));
      send_byte(8'($urandom));
    end
    drive(1'b1, BIT);
    checks++; if (ovr_n - o0 !== cnt - 1) begin errors++; $display("FAIL rovr_count got %0d want %0d", ovr_n - o0, cnt - 1); end
    checks++; if (rxbyte !== first || rx_valid !== 1'b1) begin errors++; $display("FAIL rovr_held got %h valid %b want %h 1", rxbyte, rx_valid, first); end
    rx_ready = 1'b1;
    repeat (4) @(negedge hwclk);
    checks++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== first) begin errors++; $display("FAIL rovr_consume got n=%0d byte %h want n=1 byte %h", got_n - n0, got_mem[n0[7:0]], first); end
    checks++; if (both_n !== 0) begin errors++; $display("FAIL err_overlap got %0d want 0", both_n); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, v0, p0;
    rx_ready = 1'b1;
    n0 = got_n; p0 = perr_n;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    drive(1'b1, BIT);
    checks++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h07) begin errors++; $display("FAIL parity_accept got n=%0d byte %h want n=1 byte 07", got_n - n0, got_mem[n0[7:0]]); end
    v0 = valid_cyc;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    drive(1'b1, BIT);
    checks++; if (perr_n - p0 !== 1) begin errors++; $display("FAIL parity_err got %0d want 1", perr_n - p0); end
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL parity_discard got %0d want 0", valid_cyc - v0); end
  endtask
`endif

  initial begin
    @(negedge hwclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_random_stream();
    test_random_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
